// File: rtl/lc3b_types.sv
// Shared types for the line-memory arbiter: FSM state, memory command and the 128-bit line.
package lc3b_types;

  typedef logic [127:0] mem_bus;

  localparam int unsigned MEM_BUS_WIDTH = $bits(mem_bus);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    MEM_CMD_NONE,
    MEM_CMD_READ,
    MEM_CMD_WRITE
  } lc3b_mem_cmd;

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: first requester found scanning upward from last_grant+1.
module rr_priority_sel #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDXW      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDXW-1:0]      last_grant_i,
  output logic [NUM_PORTS-1:0] grant_oh_o,
  output logic [IDXW-1:0]      grant_idx_o
);

  logic            found;
  logic [IDXW-1:0] cand;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    // last_grant itself is scanned last, so a lone repeat requester still wins.
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = IDXW'((last_grant_i + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found             = 1'b1;
        grant_oh_o[cand]  = 1'b1;
        grant_idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port round-robin arbiter onto one line-wide physical memory; one transaction in flight.
// pmem_* come straight from registers captured at grant, so requesters may change inputs freely once granted.
module mem_arbiter_n
  import lc3b_types::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = MEM_BUS_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_read,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  req_resp,
  output logic [LINE_WIDTH-1:0]                 req_rdata,
  output logic                                  pmem_read,
  output logic                                  pmem_write,
  output logic [ADDR_WIDTH-1:0]                 pmem_address,
  output logic [LINE_WIDTH-1:0]                 pmem_wdata,
  input  logic                                  pmem_resp,
  input  logic [LINE_WIDTH-1:0]                 pmem_rdata
);

  localparam int unsigned IDXW = $clog2(NUM_PORTS);

  arb_state_t                state_q, state_d;
  lc3b_mem_cmd               cmd_q, cmd_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic [IDXW-1:0]           last_q, last_d;
  logic [NUM_PORTS-1:0]      grant_oh_q, grant_oh_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [LINE_WIDTH-1:0]     wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]     rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]      req_vec;
  logic [NUM_PORTS-1:0]      sel_oh;
  logic [IDXW-1:0]           sel_idx;

  assign req_vec = req_read | req_write;

  rr_priority_sel #(
    .NUM_PORTS (NUM_PORTS),
    .IDXW      (IDXW)
  ) u_sel (
    .req_i        (req_vec),
    .last_grant_i (last_q),
    .grant_oh_o   (sel_oh),
    .grant_idx_o  (sel_idx)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    last_d     = last_q;
    grant_oh_d = grant_oh_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d    = BUSY;
          idx_d      = sel_idx;
          grant_oh_d = sel_oh;
          addr_d     = req_address[sel_idx];
          wdata_d    = req_wdata[sel_idx];
          // A port asserting both read and write is treated as a write.
          cmd_d      = req_write[sel_idx] ? MEM_CMD_WRITE : MEM_CMD_READ;
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          if (cmd_q == MEM_CMD_READ) begin
            rdata_d = pmem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= MEM_CMD_NONE;
      idx_q      <= '0;
      last_q     <= IDXW'(NUM_PORTS - 1);
      grant_oh_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      grant_oh_q <= grant_oh_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign pmem_read    = (state_q == BUSY) && (cmd_q == MEM_CMD_READ);
  assign pmem_write   = (state_q == BUSY) && (cmd_q == MEM_CMD_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign req_rdata    = rdata_q;
  assign req_resp     = (state_q == DONE) ? grant_oh_q : '0;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n (4 ports, 128-bit lines) with hand-computed expectations.
module tb_mem_arbiter_n;
  import lc3b_types::*;

  localparam int NP = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NP-1:0]        req_read = '0;
  logic [NP-1:0]        req_write = '0;
  logic [NP-1:0][15:0]  req_address = '0;
  logic [NP-1:0][127:0] req_wdata = '0;
  logic [NP-1:0]        req_resp;
  mem_bus               req_rdata;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [15:0]          pmem_address;
  mem_bus               pmem_wdata;
  logic                 pmem_resp = 1'b0;
  mem_bus               pmem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_arbiter_n #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (16),
    .LINE_WIDTH (128)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .req_resp     (req_resp),
    .req_rdata    (req_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_resp"}, req_resp, '0);
    chk({tag, "_pread"}, pmem_read, 1'b0);
    chk({tag, "_pwrite"}, pmem_write, 1'b0);
    chk({tag, "_paddr"}, pmem_address, '0);
    chk({tag, "_pwdata"}, pmem_wdata, '0);
    chk({tag, "_rdata"}, req_rdata, '0);
  endtask

  // Waits (bounded) for a pmem command, checks it, answers after 'hold' cycles, checks the response.
  task automatic do_txn(input string tag, input int exp_port, input bit exp_wr,
                        input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                        input logic [127:0] rd, input logic [127:0] exp_rdata,
                        input int hold, output int waited);
    logic [NP-1:0] oh;
    oh = '0;
    oh[exp_port] = 1'b1;
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_pread"}, pmem_read, !exp_wr);
    chk({tag, "_pwrite"}, pmem_write, exp_wr);
    chk({tag, "_paddr"}, pmem_address, exp_addr);
    if (exp_wr) chk({tag, "_pwdata"}, pmem_wdata, exp_wdata);
    repeat (hold - 1) tick();
    chk({tag, "_held"}, pmem_read | pmem_write, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    tick();
    pmem_resp  = 1'b0;
    chk({tag, "_resp"}, req_resp, oh);
    chk({tag, "_rdata"}, req_rdata, exp_rdata);
    chk({tag, "_cmd_off"}, pmem_read | pmem_write, 1'b0);
  endtask

  initial begin
    int     w;
    logic   [NP-1:0] resp_or;
    mem_bus last_rd;

    #1;
    check_zero_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Single read from port 0, memory answers in the 4th command cycle.
    req_read[0]    = 1'b1;
    req_address[0] = 16'h1230;
    tick();
    repeat (3) begin
      chk("rd_hold", pmem_read, 1'b1);
      chk("rd_noresp", req_resp, '0);
      tick();
    end
    chk("rd_hold4", pmem_read, 1'b1);
    chk("rd_addr", pmem_address, 16'h1230);
    pmem_resp  = 1'b1;
    pmem_rdata = {16{8'hA5}};
    tick();
    pmem_resp  = 1'b0;
    chk("rd_cmd_drop", pmem_read, 1'b0);
    chk("rd_resp", req_resp, 4'b0001);
    chk("rd_data", req_rdata, {16{8'hA5}});
    req_read[0] = 1'b0;
    tick();
    chk("rd_pulse_end", req_resp, '0);
    chk("rd_data_hold", req_rdata, {16{8'hA5}});

    // Ports 0 and 1 together right after reset: port 0 first.
    do_reset();
    req_address[0] = 16'h0100;
    req_address[1] = 16'h0200;
    req_read[1:0]  = 2'b11;
    do_txn("pair_p0", 0, 1'b0, 16'h0100, '0, {16{8'h11}}, {16{8'h11}}, 2, w);
    req_read[0] = 1'b0;
    do_txn("pair_p1", 1, 1'b0, 16'h0200, '0, {16{8'h22}}, {16{8'h22}}, 2, w);
    req_read[1] = 1'b0;

    // All four ports requesting continuously: strict rotation.
    do_reset();
    for (int p = 0; p < NP; p++) req_address[p] = 16'h1000 + 16'(p * 16);
    req_read = '1;
    for (int k = 0; k < 8; k++) begin
      last_rd = {16{8'(k + 1)}};
      do_txn($sformatf("rot%0d", k), k % NP, 1'b0, 16'h1000 + 16'((k % NP) * 16), '0,
             last_rd, last_rd, 2, w);
      if (k == 0) chk("first_cmd_latency", w, 1);
    end
    req_read = '0;

    // Read+write on port 1 is a write; read line must not change.
    req_read[1]    = 1'b1;
    req_write[1]   = 1'b1;
    req_address[1] = 16'h0040;
    req_wdata[1]   = {16{8'h5A}};
    do_txn("rw", 1, 1'b1, 16'h0040, {16{8'h5A}}, {16{8'hEE}}, last_rd, 2, w);
    req_read[1]  = 1'b0;
    req_write[1] = 1'b0;

    // Requester withdraws during BUSY; later pmem_resp in DONE/IDLE is ignored.
    tick();
    req_read[0]    = 1'b1;
    req_address[0] = 16'h0777;
    tick();
    chk("drop_cmd", pmem_read, 1'b1);
    req_read[0]    = 1'b0;
    req_address[0] = 16'hFFFF;
    tick();
    chk("drop_hold", pmem_read, 1'b1);
    chk("drop_addr", pmem_address, 16'h0777);
    tick();
    chk("drop_hold2", pmem_read, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = {16{8'h3C}};
    tick();
    chk("drop_resp", req_resp, 4'b0001);
    chk("drop_rdata", req_rdata, {16{8'h3C}});
    pmem_rdata = {16{8'hC3}};
    tick();
    chk("spur_resp_a", req_resp, '0);
    chk("spur_pread_a", pmem_read, 1'b0);
    tick();
    chk("spur_resp_b", req_resp, '0);
    chk("spur_cmd_b", pmem_read | pmem_write, 1'b0);
    chk("spur_rdata", req_rdata, {16{8'h3C}});
    pmem_resp = 1'b0;

    // Reset in the middle of a write from port 3.
    req_write[3]   = 1'b1;
    req_address[3] = 16'h0ABC;
    req_wdata[3]   = {16{8'h77}};
    tick();
    chk("mid_pwrite", pmem_write, 1'b1);
    chk("mid_paddr", pmem_address, 16'h0ABC);
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    req_write[3] = 1'b0;
    tick();
    rst = 1'b0;
    resp_or = '0;
    repeat (4) begin
      resp_or |= req_resp;
      tick();
    end
    chk("rst_no_resp", resp_or, '0);
    req_address[2] = 16'h0222;
    req_address[0] = 16'h0333;
    req_read[2]    = 1'b1;
    req_read[0]    = 1'b1;
    do_txn("rst_p0", 0, 1'b0, 16'h0333, '0, {16{8'h44}}, {16{8'h44}}, 2, w);
    req_read[0] = 1'b0;
    do_txn("rst_p2", 2, 1'b0, 16'h0222, '0, {16{8'h55}}, {16{8'h55}}, 2, w);
    req_read[2] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, line width in bits (mem_bus when 128).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_read, input, NUM_PORTS, per-port line read request (level).
REQ-007 SHALL have port req_write, input, NUM_PORTS, per-port line write request (level).
REQ-008 SHALL have port req_address, input, NUM_PORTS x ADDR_WIDTH, per-port line address.
REQ-009 SHALL have port req_wdata, input, NUM_PORTS x LINE_WIDTH, per-port write line.
REQ-010 SHALL have port req_resp, output, NUM_PORTS, per-port one-cycle completion pulse.
REQ-011 SHALL have port req_rdata, output, LINE_WIDTH, read line shared by all ports, valid with req_resp.
REQ-012 SHALL have port pmem_read / pmem_write, output, 1 each, physical memory command.
REQ-013 SHALL have port pmem_address, output, ADDR_WIDTH; pmem_wdata, output, LINE_WIDTH.
REQ-014 SHALL have port pmem_resp, input, 1; pmem_rdata, input, LINE_WIDTH.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE: a port is requesting if req_read or req_write is set; if any, SHALL grant one by round-robin starting at (last_grant+1) mod NUM_PORTS, go to BUSY next cycle.
REQ-017 On grant SHALL register port index, address, wdata and command; pmem_* SHALL drive from these registers only, so pmem_read/pmem_write assert exactly 1 cycle after the grant cycle.
REQ-018 Port with both req_read and req_write set SHALL be serviced as a write.
REQ-019 BUSY: SHALL hold pmem_* stable until pmem_resp; on pmem_resp SHALL capture pmem_rdata (reads only), deassert pmem_read/pmem_write next cycle, go to DONE.
REQ-020 DONE: SHALL assert req_resp[grant] for exactly one cycle with req_rdata valid (reads); all other req_resp bits 0; SHALL update last_grant; SHALL go to IDLE.
REQ-021 DONE-to-IDLE gap SHALL guarantee the serviced port may drop its request on the cycle after req_resp without being re-granted.
REQ-022 Requester deasserting or changing inputs during BUSY SHALL NOT abort or alter the transaction; req_resp SHALL still pulse.
REQ-023 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-024 Back-to-back: with all ports continuously requesting, grants SHALL rotate 0,1,...,NUM_PORTS-1,0 and no port waits more than NUM_PORTS-1 other transactions.
REQ-025 Minimum latency, request-seen to req_resp, SHALL be 3 cycles with pmem_resp returned 1 cycle after pmem command asserts.
REQ-026 req_rdata SHALL hold the last captured line between transactions.

Reset
REQ-027 rst SHALL asynchronously force state IDLE, last_grant NUM_PORTS-1 (so port 0 has first priority), req_resp 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, req_rdata 0.
REQ-028 rst asserted mid-BUSY SHALL drop the transaction with no req_resp; after release, arbitration restarts from port 0.

Structure
REQ-029 The state enum (arb_state_t) and lc3b_mem_cmd typedef SHALL be added to package lc3b_types; mem_bus SHALL be used where LINE_WIDTH is 128.
REQ-030 Round-robin selection SHALL be a sub-module rr_priority_sel (NUM_PORTS request vector, last_grant in; one-hot grant and index out), purely combinational.

Verification
REQ-031 Port0 read 0x1230, pmem_resp after 4 cycles with rdata 0xA5..A5 -> pmem_read high 4 cycles, address 0x1230, req_resp[0] 1-cycle pulse, req_rdata 0xA5..A5.
REQ-032 Ports 0 and 1 request same cycle after reset -> port 0 served first, port 1 next, req_resp never both high.
REQ-033 NUM_PORTS=4, all ports hold requests for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Port1 read+write both set, address 0x0040, wdata 0x5A..5A -> pmem_write only, pmem_wdata 0x5A..5A.
REQ-035 Port0 drops request 1 cycle into BUSY -> pmem command held until pmem_resp, req_resp[0] still pulses; spurious pmem_resp in IDLE -> no req_resp.
REQ-036 rst pulsed mid-BUSY -> all outputs 0 immediately, no req_resp; next request from port 2 and port 0 -> port 0 granted.
